// File: rtl/keyrep_pkg.sv
// Shared types and constants for the PS/2 key-repeat controller.
// Holds the scan-code decoder states, the PS/2 prefix bytes and the default arrow-key codes.
package keyrep_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BRK,
      EXT,
      EXT_BRK
   } dec_state_t;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_repeat_chan.sv
// One command channel: held flag, auto-repeat countdown and registered command pulse.
// held_next is exported so the parent can register any_held in the same cycle as held.
module key_repeat_chan
   import keyrep_pkg::*;
#(
   parameter int REPEAT_DELAY = 3,
   parameter int REPEAT_RATE  = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic make_hit,
   input  logic break_hit,
   input  logic tick,
   output logic held,
   output logic cmd,
   output logic held_next
);

   localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
   localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             cmd_next;

   // Break beats everything; a fresh make beats a coincident tick; keyboard typematic makes are dropped.
   always_comb begin
      held_next = held;
      cnt_next  = cnt;
      cmd_next  = 1'b0;
      if (break_hit) begin
         held_next = 1'b0;
         cnt_next  = '0;
      end else if (make_hit && !held) begin
         held_next = 1'b1;
         cmd_next  = 1'b1;
         cnt_next  = DELAY_LOAD;
      end else if (tick && held && (cnt != '0)) begin
         if (cnt == CNT_ONE) begin
            cmd_next = 1'b1;
            cnt_next = RATE_LOAD;
         end else begin
            cnt_next = cnt - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         held <= 1'b0;
         cmd  <= 1'b0;
         cnt  <= '0;
      end else begin
         held <= held_next;
         cmd  <= cmd_next;
         cnt  <= cnt_next;
      end
   end

endmodule

// File: rtl/key_repeat_ctrl.sv
// PS/2 scan-code decoder with per-channel held flags and programmable auto-repeat command pulses.
// Optional macro KEYREP_EXT_MATCH_EN: channels also require the E0 prefix state to equal KEY_EXT[i].
module key_repeat_ctrl
   import keyrep_pkg::*;
#(
   parameter int                    NUM_KEYS     = 4,
   parameter logic [NUM_KEYS*8-1:0] KEY_CODES    = {KEY_DOWN, KEY_UP, KEY_RIGHT, KEY_LEFT},
   parameter logic [NUM_KEYS-1:0]   KEY_EXT      = '1,
   parameter int                    TICK_DIV     = 5000000,
   parameter int                    REPEAT_DELAY = 3,
   parameter int                    REPEAT_RATE  = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ps2_key_pressed,
   input  logic [7:0]          ps2_key_data,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_cmd,
   output logic                any_held,
   output logic [7:0]          last_code
);

   localparam int PRESC_W = $clog2(TICK_DIV + 1);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

   dec_state_t          state;
   dec_state_t          state_next;
   logic                dec_make;
   logic                dec_break;
   logic                dec_ext;
   logic [PRESC_W-1:0]  presc;
   logic                tick;
   logic [NUM_KEYS-1:0] held_next;

   assign tick = (presc == PRESC_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         presc     <= '0;
         last_code <= 8'h00;
         any_held  <= 1'b0;
      end else begin
         state    <= state_next;
         presc    <= tick ? '0 : presc + PRESC_ONE;
         any_held <= |held_next;
         if (dec_make || dec_break) begin
            last_code <= ps2_key_data;
         end
      end
   end

   // Prefix bytes only move the state; any other byte completes a make or break and returns to IDLE.
   always_comb begin
      state_next = state;
      dec_make   = 1'b0;
      dec_break  = 1'b0;
      dec_ext    = 1'b0;
      if (ps2_key_pressed) begin
         case (state)
            IDLE: begin
               if (ps2_key_data == PS2_EXT)        state_next = EXT;
               else if (ps2_key_data == PS2_BREAK) state_next = BRK;
               else                                dec_make   = 1'b1;
            end
            EXT: begin
               if (ps2_key_data == PS2_BREAK)      state_next = EXT_BRK;
               else if (ps2_key_data == PS2_EXT)   state_next = EXT;
               else begin
                  dec_make   = 1'b1;
                  dec_ext    = 1'b1;
                  state_next = IDLE;
               end
            end
            BRK: begin
               if (ps2_key_data == PS2_EXT)        state_next = EXT_BRK;
               else if (ps2_key_data == PS2_BREAK) state_next = BRK;
               else begin
                  dec_break  = 1'b1;
                  state_next = IDLE;
               end
            end
            EXT_BRK: begin
               if ((ps2_key_data != PS2_EXT) && (ps2_key_data != PS2_BREAK)) begin
                  dec_break  = 1'b1;
                  dec_ext    = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

`ifndef KEYREP_EXT_MATCH_EN
   logic unused_ext;
   assign unused_ext = ^{KEY_EXT, dec_ext};
`endif

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
      logic code_hit;
`ifdef KEYREP_EXT_MATCH_EN
      assign code_hit = (ps2_key_data == KEY_CODES[8*i +: 8]) && (dec_ext == KEY_EXT[i]);
`else
      assign code_hit = (ps2_key_data == KEY_CODES[8*i +: 8]);
`endif

      key_repeat_chan #(
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_chan (
         .clock     (clock),
         .reset     (reset),
         .make_hit  (dec_make && code_hit),
         .break_hit (dec_break && code_hit),
         .tick      (tick),
         .held      (key_held[i]),
         .cmd       (key_cmd[i]),
         .held_next (held_next[i])
      );
   end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Scoreboard testbench for key_repeat_ctrl: a behavioural model queues expected outputs per cycle.
// Honours KEYREP_EXT_MATCH_EN the same way the design does.
module tb_key_repeat_ctrl;
   import keyrep_pkg::*;

   localparam int NUM_KEYS     = 4;
   localparam int TICK_DIV     = 1;
   localparam int REPEAT_DELAY = 3;
   localparam int REPEAT_RATE  = 2;
   localparam logic [31:0] CODES = {8'h72, 8'h75, 8'h74, 8'h6B};
   localparam logic [3:0]  EXTS  = 4'b1111;

   logic       clock = 1'b0;
   logic       reset;
   logic       ps2_key_pressed;
   logic [7:0] ps2_key_data;
   logic [3:0] key_held;
   logic [3:0] key_cmd;
   logic       any_held;
   logic [7:0] last_code;

   key_repeat_ctrl #(
      .NUM_KEYS     (NUM_KEYS),
      .KEY_CODES    (CODES),
      .KEY_EXT      (EXTS),
      .TICK_DIV     (TICK_DIV),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .ps2_key_pressed (ps2_key_pressed),
      .ps2_key_data    (ps2_key_data),
      .key_held        (key_held),
      .key_cmd         (key_cmd),
      .any_held        (any_held),
      .last_code       (last_code)
   );

   always #5 clock = ~clock;

   logic [16:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          pulse_cnt[4];

   // Reference model state: 0 idle, 1 break seen, 2 E0 seen, 3 E0+F0 seen
   int         m_state;
   int         m_presc;
   int         m_cnt[4];
   logic [3:0] m_held;
   logic [3:0] m_cmd;
   logic [7:0] m_last;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelStep(input logic rst, input logic stb, input logic [7:0] d);
      logic tk, mk, br, ex, hit;
      if (rst) begin
         m_state = 0; m_presc = 0; m_held = '0; m_cmd = '0; m_last = 8'h00;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
         tk = (m_presc == TICK_DIV - 1);
         m_presc = tk ? 0 : m_presc + 1;
         mk = 1'b0; br = 1'b0; ex = 1'b0;
         if (stb) begin
            if (d == 8'hE0) begin
               m_state = (m_state == 1 || m_state == 3) ? 3 : 2;
            end else if (d == 8'hF0) begin
               m_state = (m_state == 2 || m_state == 3) ? 3 : 1;
            end else begin
               ex = (m_state == 2 || m_state == 3);
               mk = (m_state == 0 || m_state == 2);
               br = !mk;
               m_state = 0;
            end
         end
         if (mk || br) m_last = d;
         for (int i = 0; i < 4; i++) begin
            hit = (d == CODES[8*i +: 8]);
`ifdef KEYREP_EXT_MATCH_EN
            hit = hit && (ex == EXTS[i]);
`endif
            m_cmd[i] = 1'b0;
            if (br && hit) begin
               m_held[i] = 1'b0;
               m_cnt[i]  = 0;
            end else if (mk && hit && !m_held[i]) begin
               m_held[i] = 1'b1;
               m_cmd[i]  = 1'b1;
               m_cnt[i]  = REPEAT_DELAY;
            end else if (tk && m_held[i] && m_cnt[i] > 0) begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) begin
                  m_cmd[i] = 1'b1;
                  m_cnt[i] = REPEAT_RATE;
               end
            end
         end
      end
      exp_q.push_back({m_held, m_cmd, |m_held, m_last});
   endtask

   // One clock cycle: drive, predict, then compare the registered outputs 1 time unit after the edge.
   task automatic applyStimulus(input logic rst, input logic stb, input logic [7:0] d);
      logic [16:0] observed;
      reset           = rst;
      ps2_key_pressed = stb;
      ps2_key_data    = d;
      modelStep(rst, stb, d);
      @(posedge clock);
      #1;
      observed = {key_held, key_cmd, any_held, last_code};
      if (exp_q.size() == 0) checkOutput("scoreboard_empty", 32'd1, 32'd0);
      else checkOutput("outputs", 32'(observed), 32'(exp_q.pop_front()));
      for (int i = 0; i < 4; i++) if (key_cmd[i]) pulse_cnt[i]++;
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(1'b0, 1'b1, b);
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic clearPulses();
      for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
   endtask

   initial begin
      logic [7:0] pool [7];
      pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C};
      reset = 1'b1; ps2_key_pressed = 1'b0; ps2_key_data = 8'h00;
      clearPulses();

      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 8'h6B);
      checkOutput("reset_state", {15'd0, key_held, key_cmd, any_held, last_code}, 32'd0);

      // Left arrow held: pulses at +1,+4,+6,+8,+10,+12; the break lands on the next repeat slot.
      sendByte(8'hE0);
      clearPulses();
      sendByte(8'h6B);
      checkOutput("left_first_held", 32'(key_held[0]), 32'd1);
      idleCycles(10);
      sendByte(8'hE0);
      sendByte(8'hF0);
      sendByte(8'h6B);
      checkOutput("left_break_cmd", 32'(key_cmd[0]), 32'd0);
      checkOutput("left_break_held", 32'(key_held[0]), 32'd0);
      checkOutput("left_pulse_count", 32'(pulse_cnt[0]), 32'd6);
      idleCycles(4);
      checkOutput("left_quiet_after_break", 32'(pulse_cnt[0]), 32'd6);

      // Up arrow made twice: the second make neither pulses nor reloads, so one repeat lands before the break.
      sendByte(8'hE0);
      clearPulses();
      sendByte(8'h75);
      sendByte(8'hE0);
      sendByte(8'h75);
      checkOutput("up_typematic_cmd", 32'(key_cmd[2]), 32'd0);
      sendByte(8'hE0);
      sendByte(8'hF0);
      sendByte(8'h75);
      checkOutput("up_pulse_count", 32'(pulse_cnt[2]), 32'd2);
      checkOutput("up_released", 32'(key_held[2]), 32'd0);

      // Left and right together, release left only.
      sendByte(8'hE0);
      sendByte(8'h6B);
      sendByte(8'hE0);
      sendByte(8'h74);
      sendByte(8'hF0);
      sendByte(8'h6B);
      clearPulses();
      idleCycles(6);
      checkOutput("dual_left_stopped", 32'(pulse_cnt[0]), 32'd0);
      checkOutput("dual_right_repeats", 32'(pulse_cnt[1]), 32'd3);
      checkOutput("dual_any_held", 32'(any_held), 32'd1);
      sendByte(8'hF0);
      sendByte(8'h74);
      checkOutput("dual_any_released", 32'(any_held), 32'd0);

      // Stray break of a key that is not held.
      sendByte(8'hF0);
      sendByte(8'h72);
      checkOutput("stray_break_last", 32'(last_code), 32'h72);

      // Reset between prefix bytes drops the pending E0.
      sendByte(8'hE0);
      sendByte(8'h72);
      sendByte(8'hE0);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("midseq_reset_outputs", {15'd0, key_held, key_cmd, any_held, last_code}, 32'd0);
      applyStimulus(1'b1, 1'b0, 8'h00);
      sendByte(8'h6B);
`ifdef KEYREP_EXT_MATCH_EN
      checkOutput("midseq_restart_held", 32'(key_held), 32'd0);
`else
      checkOutput("midseq_restart_held", 32'(key_held), 32'd1);
`endif
      checkOutput("midseq_restart_last", 32'(last_code), 32'h6B);
      sendByte(8'hF0);
      sendByte(8'h6B);

`ifdef KEYREP_EXT_MATCH_EN
      sendByte(8'h75);
      checkOutput("numpad8_ignored", 32'(key_held[2]), 32'd0);
      checkOutput("numpad8_last", 32'(last_code), 32'h75);
      sendByte(8'hE0);
      sendByte(8'h75);
      checkOutput("arrow_up_cmd", 32'(key_cmd[2]), 32'd1);
      sendByte(8'hE0);
      sendByte(8'hF0);
      sendByte(8'h75);
`else
      sendByte(8'h75);
      checkOutput("plain_up_cmd", 32'(key_cmd[2]), 32'd1);
      checkOutput("plain_up_last", 32'(last_code), 32'h75);
      sendByte(8'hF0);
      sendByte(8'h75);
`endif
      checkOutput("up_final_released", 32'(key_held[2]), 32'd0);

      // Random byte stream including stacked prefixes, checked purely against the model.
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'b0, ($urandom_range(0, 2) != 0), pool[$urandom_range(0, 6)]);
      end

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
